pba_packetizer: RTL and testbench

PBA_PACKETIZER -- requirements
Module: pba_packetizer

---
 rtl/pba_packetizer.sv | 162 ++++++++++++++++
 tb/tb_pba_packetizer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pba_packetizer.sv
// Pooling/bias/activation packetizer: latches layer config, accepts POOL_NUM-lane beats
// and tags each registered output beat with its window position (VALID/FINISH/COMPL).
//
// state  | meaning
// IDLE   | waiting for cfg_start; no beats accepted
// RUN    | accepting beats, counting elements and windows
// DONE   | one-cycle end-of-layer, done=1
module pba_packetizer #(
   parameter int DATA_WID = 16,
   parameter int POOL_NUM = 4,
   parameter int CNT_WID  = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         cfg_start,
   input  logic [CNT_WID-1:0]           cfg_win_size,
   input  logic [CNT_WID-1:0]           cfg_win_num,
   input  logic                         cfg_mode,
   input  logic                         cfg_if_pool,
   input  logic                         cfg_if_bias,
   input  logic                         cfg_if_act,
   input  logic                         cfg_if_lstm,
   input  logic [POOL_NUM*DATA_WID-1:0] cfg_bias,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [POOL_NUM*DATA_WID-1:0] in_data,
   input  logic [POOL_NUM-1:0]          in_mask,
   output logic                         out_if_pool,
   output logic                         out_if_bias,
   output logic                         out_if_act,
   output logic                         out_if_lstm,
   output logic [1:0]                   out_pool_state,
   output logic                         out_pool_op_mode,
   output logic [CNT_WID-1:0]           out_avg_num,
   output logic [POOL_NUM*DATA_WID-1:0] out_data,
   output logic [POOL_NUM*DATA_WID-1:0] out_bias,
   output logic [POOL_NUM-1:0]          out_valid,
   output logic                         busy,
   output logic                         done
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [1:0] PS_INVALID = 2'd0;
   localparam logic [1:0] PS_VALID   = 2'd1;
   localparam logic [1:0] PS_FINISH  = 2'd2;
   localparam logic [1:0] PS_COMPL   = 2'd3;

   state_t                      r_state;
   state_t                      w_state_nxt;
   logic [CNT_WID-1:0]          r_elem_cnt;
   logic [CNT_WID-1:0]          r_win_cnt;
   logic [CNT_WID-1:0]          r_win_num;
   logic [CNT_WID-1:0]          r_avg_num;
   logic                        r_mode;
   logic                        r_if_pool;
   logic                        r_if_bias;
   logic                        r_if_act;
   logic                        r_if_lstm;
   logic [POOL_NUM*DATA_WID-1:0] r_bias;
   logic [1:0]                  r_pool_state;
   logic [POOL_NUM-1:0]         r_out_valid;
   logic [POOL_NUM*DATA_WID-1:0] r_out_data;

   logic                        w_accept;
   logic                        w_cfg_load;
   logic                        w_last_elem;
   logic                        w_last_win;
   logic [CNT_WID-1:0]          w_win_eff;

   assign w_accept    = in_valid && (r_state == S_RUN);
   assign w_cfg_load  = cfg_start && (r_state == S_IDLE);
   assign w_last_elem = (r_elem_cnt == r_avg_num - CNT_WID'(1));
   assign w_last_win  = (r_win_cnt == r_win_num - CNT_WID'(1));

   // A zero window size with pooling enabled degenerates to single-beat windows.
   always_comb begin
      w_win_eff = CNT_WID'(1);
      if (cfg_if_pool && (cfg_win_size != '0))
         w_win_eff = cfg_win_size;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (cfg_start) w_state_nxt = (cfg_win_num != '0) ? S_RUN : S_DONE;
         S_RUN:   if (w_accept && w_last_elem && w_last_win) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_elem_cnt <= '0;
         r_win_cnt  <= '0;
         r_win_num  <= '0;
         r_avg_num  <= '0;
         r_mode     <= 1'b0;
         r_if_pool  <= 1'b0;
         r_if_bias  <= 1'b0;
         r_if_act   <= 1'b0;
         r_if_lstm  <= 1'b0;
         r_bias     <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_cfg_load) begin
            r_elem_cnt <= '0;
            r_win_cnt  <= '0;
            r_win_num  <= cfg_win_num;
            r_avg_num  <= w_win_eff;
            r_mode     <= cfg_mode;
            r_if_pool  <= cfg_if_pool;
            r_if_bias  <= cfg_if_bias;
            r_if_act   <= cfg_if_act;
            r_if_lstm  <= cfg_if_lstm;
            r_bias     <= cfg_bias;
         end else if (w_accept) begin
            if (w_last_elem) begin
               r_elem_cnt <= '0;
               r_win_cnt  <= r_win_cnt + CNT_WID'(1);
            end else begin
               r_elem_cnt <= r_elem_cnt + CNT_WID'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pool_state <= PS_INVALID;
         r_out_valid  <= '0;
         r_out_data   <= '0;
      end else if (w_accept) begin
         r_out_valid <= in_mask;
         r_out_data  <= in_data;
         if (w_last_elem && w_last_win) r_pool_state <= PS_COMPL;
         else if (w_last_elem)          r_pool_state <= PS_FINISH;
         else                           r_pool_state <= PS_VALID;
      end else begin
         r_pool_state <= PS_INVALID;
         r_out_valid  <= '0;
         r_out_data   <= '0;
      end
   end

   assign in_ready         = (r_state == S_RUN);
   assign busy             = (r_state == S_RUN);
   assign done             = (r_state == S_DONE);
   assign out_if_pool      = r_if_pool;
   assign out_if_bias      = r_if_bias;
   assign out_if_act       = r_if_act;
   assign out_if_lstm      = r_if_lstm;
   assign out_pool_op_mode = r_mode;
   assign out_avg_num      = r_avg_num;
   assign out_bias         = r_bias;
   assign out_pool_state   = r_pool_state;
   assign out_valid        = r_out_valid;
   assign out_data         = r_out_data;

endmodule

// File: tb/tb_pba_packetizer.sv
// Scoreboard bench for pba_packetizer: driver queues expected beats from a window/position
// model, a negedge monitor pops and compares every presented beat.
module tb_pba_packetizer;

   localparam int DW = 16;
   localparam int PN = 4;
   localparam int CW = 16;
   localparam int BW = DW * PN;

   typedef struct {
      logic [1:0]    st;
      logic [PN-1:0] mask;
      logic [BW-1:0] data;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          cfg_start;
   logic [CW-1:0] cfg_win_size;
   logic [CW-1:0] cfg_win_num;
   logic          cfg_mode, cfg_if_pool, cfg_if_bias, cfg_if_act, cfg_if_lstm;
   logic [BW-1:0] cfg_bias;
   logic          in_valid;
   logic          in_ready;
   logic [BW-1:0] in_data;
   logic [PN-1:0] in_mask;
   logic          out_if_pool, out_if_bias, out_if_act, out_if_lstm;
   logic [1:0]    out_pool_state;
   logic          out_pool_op_mode;
   logic [CW-1:0] out_avg_num;
   logic [BW-1:0] out_data, out_bias;
   logic [PN-1:0] out_valid;
   logic          busy, done;

   int n_vec = 0;
   int n_err = 0;
   exp_t sb[$];

   logic [CW-1:0] exp_avg;
   logic          exp_mode;
   logic [3:0]    exp_en;
   logic [BW-1:0] exp_bias;

   pba_packetizer #(.DATA_WID(DW), .POOL_NUM(PN), .CNT_WID(CW)) dut (
      .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_win_size(cfg_win_size),
      .cfg_win_num(cfg_win_num), .cfg_mode(cfg_mode), .cfg_if_pool(cfg_if_pool),
      .cfg_if_bias(cfg_if_bias), .cfg_if_act(cfg_if_act), .cfg_if_lstm(cfg_if_lstm),
      .cfg_bias(cfg_bias), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_mask(in_mask), .out_if_pool(out_if_pool), .out_if_bias(out_if_bias),
      .out_if_act(out_if_act), .out_if_lstm(out_if_lstm), .out_pool_state(out_pool_state),
      .out_pool_op_mode(out_pool_op_mode), .out_avg_num(out_avg_num), .out_data(out_data),
      .out_bias(out_bias), .out_valid(out_valid), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (out_pool_state != 2'd0) begin
            if (sb.size() == 0) begin
               chk("unexpected_beat", {126'd0, out_pool_state}, 128'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("pool_state", {126'd0, out_pool_state}, {126'd0, e.st});
               chk("out_valid", {124'd0, out_valid}, {124'd0, e.mask});
               chk("out_data", {64'd0, out_data}, {64'd0, e.data});
               chk("avg_num", {112'd0, out_avg_num}, {112'd0, exp_avg});
               chk("op_mode", {127'd0, out_pool_op_mode}, {127'd0, exp_mode});
               chk("enables", {124'd0, out_if_pool, out_if_bias, out_if_act, out_if_lstm},
                   {124'd0, exp_en});
               chk("out_bias", {64'd0, out_bias}, {64'd0, exp_bias});
               if (e.st == 2'd3) chk("done_with_compl", {127'd0, done}, 128'd1);
            end
         end else begin
            chk("idle_beat_zero", {60'd0, out_valid, out_data}, 128'd0);
         end
      end
   end

   // Window model: beat i of a layer with eff-beat windows and wn windows.
   function automatic logic [1:0] beat_state(int i, int eff, int wn);
      if (i == eff * wn - 1) return 2'd3;
      if ((i % eff) == eff - 1) return 2'd2;
      return 2'd1;
   endfunction

   task automatic check_reset_zero();
      chk("rst_state", {126'd0, out_pool_state}, 128'd0);
      chk("rst_data_valid", {60'd0, out_valid, out_data}, 128'd0);
      chk("rst_bias", {64'd0, out_bias}, 128'd0);
      chk("rst_cfg_out", {112'd0, out_avg_num} | {122'd0, out_pool_op_mode, out_if_pool,
          out_if_bias, out_if_act, out_if_lstm, 1'b0}, 128'd0);
      chk("rst_ctrl", {125'd0, in_ready, busy, done}, 128'd0);
   endtask

   // gap<0 means a fixed gap of -gap cycles; mpat: 0 random, 1 one-hot, 2 all lanes.
   task automatic run_layer(input int ws, input int wn, input bit mode, input bit pool,
                            input int gap, input int mpat, input bit junk, input int abort_at);
      int eff, total, g;
      exp_t e;
      eff = (!pool || ws == 0) ? 1 : ws;
      total = eff * wn;
      cfg_win_size = CW'(ws);
      cfg_win_num  = CW'(wn);
      cfg_mode     = mode;
      cfg_if_pool  = pool;
      cfg_if_bias  = 1'($urandom);
      cfg_if_act   = 1'($urandom);
      cfg_if_lstm  = 1'($urandom);
      cfg_bias     = {$urandom, $urandom};
      exp_avg  = CW'(eff);
      exp_mode = mode;
      exp_en   = {pool, cfg_if_bias, cfg_if_act, cfg_if_lstm};
      exp_bias = cfg_bias;
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      chk("avg_num_cfg", {112'd0, out_avg_num}, {112'd0, CW'(eff)});
      if (wn == 0) begin
         chk("zero_done", {127'd0, done}, 128'd1);
         chk("zero_ready", {127'd0, in_ready}, 128'd0);
      end else begin
         chk("busy_run", {127'd0, busy}, 128'd1);
         for (int i = 0; i < total; i++) begin
            if (i == abort_at) begin
               #2 reset = 1'b1;
               #1 check_reset_zero();
               #1 reset = 1'b0;
               return;
            end
            g = (gap < 0) ? -gap : int'($urandom_range(gap, 0));
            repeat (g) @(negedge clk);
            chk("in_ready", {127'd0, in_ready}, 128'd1);
            in_data = {$urandom, $urandom};
            case (mpat)
               1:       in_mask = PN'(1 << (i % PN));
               2:       in_mask = '1;
               default: in_mask = PN'($urandom);
            endcase
            e.st = beat_state(i, eff, wn);
            e.mask = in_mask;
            e.data = in_data;
            sb.push_back(e);
            in_valid = 1'b1;
            if (junk && i == 0) begin
               cfg_start    = 1'b1;
               cfg_win_num  = CW'(wn + 3);
               cfg_win_size = CW'(ws + 2);
               cfg_mode     = ~mode;
               cfg_if_pool  = ~pool;
               cfg_bias     = ~cfg_bias;
            end
            @(negedge clk);
            in_valid  = 1'b0;
            cfg_start = 1'b0;
         end
         chk("done_pulse", {127'd0, done}, 128'd1);
         chk("busy_end", {127'd0, busy}, 128'd0);
      end
      @(negedge clk);
      chk("done_clear", {127'd0, done}, 128'd0);
      chk("idle_ready", {127'd0, in_ready}, 128'd0);
   endtask

   initial begin
      reset = 1'b1;
      cfg_start = 1'b0; cfg_win_size = '0; cfg_win_num = '0; cfg_mode = 1'b0;
      cfg_if_pool = 1'b0; cfg_if_bias = 1'b0; cfg_if_act = 1'b0; cfg_if_lstm = 1'b0;
      cfg_bias = '0; in_valid = 1'b0; in_data = '0; in_mask = '0;
      exp_avg = '0; exp_mode = 1'b0; exp_en = '0; exp_bias = '0;
      #1 check_reset_zero();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      run_layer(3, 2, 1'b1, 1'b1, 0, 2, 1'b0, -1);
      run_layer(4, 1, 1'b0, 1'b1, 0, 1, 1'b0, -1);
      run_layer(5, 3, 1'b0, 1'b0, 0, 0, 1'b0, -1);
      run_layer(3, 0, 1'b1, 1'b1, 0, 0, 1'b0, -1);
      run_layer(2, 1, 1'b1, 1'b1, -2, 0, 1'b1, -1);
      run_layer(0, 2, 1'b0, 1'b1, 1, 0, 1'b0, -1);

      run_layer(4, 1, 1'b1, 1'b1, 0, 2, 1'b0, 2);
      chk("sb_after_reset", 128'(sb.size()), 128'd0);
      exp_avg = '0; exp_mode = 1'b0; exp_en = '0; exp_bias = '0;
      repeat (2) @(negedge clk);
      chk("no_done_after_abort", {127'd0, done}, 128'd0);
      run_layer(4, 1, 1'b0, 1'b1, 0, 2, 1'b0, -1);

      for (int k = 0; k < 25; k++) begin
         run_layer(int'($urandom_range(5, 0)), int'($urandom_range(3, 0)), 1'($urandom),
                   1'($urandom), 2, 0, 1'($urandom), -1);
      end

      repeat (3) @(negedge clk);
      chk("sb_empty", 128'(sb.size()), 128'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
